// File: rtl/pipe_stage_ctrl.sv
// pipe_stage_ctrl: in-order pipeline handshake (valid/allow_in/load), partial flush, perf counters
module pipe_stage_ctrl #(
  parameter int NSTAGE = 5,
  parameter int LVL_W  = 3,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NSTAGE-1:0] over,
  input  logic              flush_req,
  input  logic [LVL_W-1:0]  flush_lvl,
  input  logic              cnt_clr,
  output logic [NSTAGE-1:0] valid,
  output logic [NSTAGE-1:0] allow_in,
  output logic [NSTAGE-1:0] load,
  output logic              fetch_en,
  output logic [LVL_W:0]    occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);
  logic [NSTAGE-1:0] kill, go;
  logic              stall_inc;
  always_comb begin
    kill      = '0;
    go        = '0;
    allow_in  = '0;
    load      = '0;
    occupancy = '0;
    for (int i = 0; i < NSTAGE; i++) begin
      kill[i]   = flush_req && (int'(flush_lvl) >= i);
      go[i]     = valid[i] & over[i] & ~kill[i];
      occupancy = occupancy + (LVL_W+1)'(valid[i]);
    end
    allow_in[NSTAGE-1] = ~valid[NSTAGE-1] | over[NSTAGE-1];
    for (int i = NSTAGE-2; i >= 1; i--) allow_in[i] = ~valid[i] | (over[i] & allow_in[i+1]);
    allow_in[0] = (over[0] & allow_in[1]) | flush_req;
    for (int i = 1; i < NSTAGE; i++) load[i] = go[i-1] & allow_in[i];
    fetch_en  = valid[0] & allow_in[0];
    stall_inc = valid[0] & over[0] & ~allow_in[1] & ~flush_req;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid     <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      valid[0] <= 1'b1;
      for (int i = 1; i < NSTAGE; i++)
        valid[i] <= kill[i] ? 1'b0 : allow_in[i] ? go[i-1] : valid[i];
      stall_cnt <= cnt_clr ? '0 : (stall_inc && !(&stall_cnt)) ? stall_cnt + 1'b1 : stall_cnt;
      flush_cnt <= cnt_clr ? '0 : (flush_req && !(&flush_cnt)) ? flush_cnt + 1'b1 : flush_cnt;
    end
  end
endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// tb_pipe_stage_ctrl: directed vectors with a scoreboard queue checked on the falling edge
module tb_pipe_stage_ctrl;
  localparam int N = 5, LW = 3, CW = 4;
  logic clk = 0, resetn = 0, flush_req = 0, cnt_clr = 0;
  logic [N-1:0] over = '1;
  logic [LW-1:0] flush_lvl = '0;
  logic [N-1:0] valid, allow_in, load;
  logic fetch_en;
  logic [LW:0] occupancy;
  logic [CW-1:0] stall_cnt, flush_cnt;
  typedef struct {
    logic [N-1:0] v, ai, ld;
    logic fe;
    int occ, st, fl;
  } exp_t;
  exp_t q[$];
  int n_vec = 0, n_err = 0;
  pipe_stage_ctrl #(.NSTAGE(N), .LVL_W(LW), .CNT_W(CW)) dut (
    .clk(clk), .resetn(resetn), .over(over), .flush_req(flush_req), .flush_lvl(flush_lvl),
    .cnt_clr(cnt_clr), .valid(valid), .allow_in(allow_in), .load(load), .fetch_en(fetch_en),
    .occupancy(occupancy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  always #5 clk = ~clk;
  function automatic void chk(string nm, int a, int e);
    if (a != e) begin
      n_err++;
      $display("FAIL vec%0d %s: got %0h expected %0h", n_vec, nm, a, e);
    end
  endfunction
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (q.size() > 0) begin
      e = q.pop_front();
      n_vec++;
      chk("valid", int'(valid), int'(e.v));
      chk("allow_in", int'(allow_in), int'(e.ai));
      chk("load", int'(load), int'(e.ld));
      chk("fetch_en", int'(fetch_en), int'(e.fe));
      chk("occupancy", int'(occupancy), e.occ);
      chk("stall_cnt", int'(stall_cnt), e.st);
      chk("flush_cnt", int'(flush_cnt), e.fl);
    end
  end
  task automatic vec(input logic rn, input logic [N-1:0] ov, input logic fr, input logic [LW-1:0] lv,
                     input logic clr, input logic [N-1:0] v, input logic [N-1:0] ai, input logic [N-1:0] ld,
                     input logic fe, input int occ, input int st, input int fl);
    exp_t e;
    @(posedge clk);
    #1;
    resetn = rn; over = ov; flush_req = fr; flush_lvl = lv; cnt_clr = clr;
    e.v = v; e.ai = ai; e.ld = ld; e.fe = fe; e.occ = occ; e.st = st; e.fl = fl;
    q.push_back(e);
  endtask
  task automatic refill(input int st, input int fl);
    vec(1, 5'b11111, 0, 0, 0, 5'b00000, 5'b11111, 5'b00000, 0, 0, st, fl);
    vec(1, 5'b11111, 0, 0, 0, 5'b00001, 5'b11111, 5'b00010, 1, 1, st, fl);
    vec(1, 5'b11111, 0, 0, 0, 5'b00011, 5'b11111, 5'b00110, 1, 2, st, fl);
    vec(1, 5'b11111, 0, 0, 0, 5'b00111, 5'b11111, 5'b01110, 1, 3, st, fl);
    vec(1, 5'b11111, 0, 0, 0, 5'b01111, 5'b11111, 5'b11110, 1, 4, st, fl);
    vec(1, 5'b11111, 0, 0, 0, 5'b11111, 5'b11111, 5'b11110, 1, 5, st, fl);
  endtask
  initial begin
    vec(0, 5'b11111, 0, 0, 0, 5'b00000, 5'b11111, 5'b00000, 0, 0, 0, 0);
    refill(0, 0);
    vec(1, 5'b10111, 0, 0, 0, 5'b11111, 5'b10000, 5'b00000, 0, 5, 0, 0);
    vec(1, 5'b10111, 0, 0, 0, 5'b01111, 5'b10000, 5'b00000, 0, 4, 1, 0);
    vec(1, 5'b10111, 0, 0, 0, 5'b01111, 5'b10000, 5'b00000, 0, 4, 2, 0);
    vec(1, 5'b11111, 0, 0, 0, 5'b01111, 5'b11111, 5'b11110, 1, 4, 3, 0);
    vec(1, 5'b11111, 1, 2, 0, 5'b11111, 5'b11111, 5'b10000, 1, 5, 3, 0);
    vec(1, 5'b11111, 0, 0, 0, 5'b10001, 5'b11111, 5'b00010, 1, 2, 3, 1);
    vec(1, 5'b11111, 1, 7, 0, 5'b00011, 5'b11111, 5'b00000, 1, 2, 3, 1);
    vec(1, 5'b11111, 0, 0, 0, 5'b00001, 5'b11111, 5'b00010, 1, 1, 3, 2);
    for (int k = 0; k < 14; k++)
      vec(1, 5'b11101, 0, 0, 0, 5'b00011, 5'b11100, 5'b00000, 0, 2, (3 + k > 15) ? 15 : 3 + k, 2);
    vec(1, 5'b11101, 0, 0, 0, 5'b00011, 5'b11100, 5'b00000, 0, 2, 15, 2);
    vec(1, 5'b11101, 0, 0, 1, 5'b00011, 5'b11100, 5'b00000, 0, 2, 15, 2);
    vec(1, 5'b11101, 0, 0, 0, 5'b00011, 5'b11100, 5'b00000, 0, 2, 0, 0);
    vec(1, 5'b11111, 0, 0, 0, 5'b00011, 5'b11111, 5'b00110, 1, 2, 1, 0);
    vec(1, 5'b11111, 0, 0, 0, 5'b00111, 5'b11111, 5'b01110, 1, 3, 1, 0);
    vec(1, 5'b11111, 0, 0, 0, 5'b01111, 5'b11111, 5'b11110, 1, 4, 1, 0);
    vec(1, 5'b11111, 0, 0, 0, 5'b11111, 5'b11111, 5'b11110, 1, 5, 1, 0);
    vec(0, 5'b11111, 0, 0, 0, 5'b00000, 5'b11111, 5'b00000, 0, 0, 0, 0);
    refill(0, 0);
    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d vectors left unchecked, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
